// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port round-robin arbiter in front of a 32-word memory.
//               Port 0 is instruction fetch, port 1 is load/store. One access
//               is in flight at a time: IDLE -> ACCESS (WAIT_STATES+1 cycles)
//               -> RESP (one-cycle response strobe) -> IDLE.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               req_*            - per-port request channel (valid/ready,
//                                  write flag, byte address, store data)
//               resp_valid/rdata - per-port response strobe, shared read data
//               mem_*            - memory side (enable, write strobe,
//                                  word index, write data, read data)
//               busy             - high while an access is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_we,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [4:0]       mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             busy
);

    localparam logic [3:0] c_WAIT_LOAD = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_rr_ptr;
    logic        r_port;
    logic        r_we;
    logic [3:0]  r_cnt;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;

    logic        w_win;
    logic        w_accept;
    logic        w_last;

    // The round-robin pointer only matters when both ports contend.
    always_comb begin
        w_win = 1'b0;
        case (req_valid)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = r_rr_ptr;
            default: w_win = 1'b0;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && !reset && (req_valid != 2'b00);
    assign w_last    = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    assign req_ready = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;

    // Strobes are masked by reset so an abandoned access never leaks a
    // write or a response during the reset cycle itself.
    assign mem_en     = (r_state == S_ACCESS) && !reset;
    assign mem_we     = w_last && r_we && !reset;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign resp_valid = ((r_state == S_RESP) && !reset) ? (r_port ? 2'b10 : 2'b01) : 2'b00;
    assign resp_rdata = r_resp;
    assign busy       = (r_state != S_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= 1'b0;
            r_port   <= 1'b0;
            r_we     <= 1'b0;
            r_cnt    <= 4'd0;
            r_addr   <= 5'd0;
            r_wdata  <= 32'd0;
            r_resp   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Byte address -> word index; the upper bits wrap.
                        r_port   <= w_win;
                        r_we     <= req_we[w_win];
                        r_addr   <= req_addr[w_win][6:2];
                        r_wdata  <= req_wdata[w_win];
                        r_cnt    <= c_WAIT_LOAD;
                        r_rr_ptr <= ~w_win;
                        r_state  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_resp  <= r_we ? 32'd0 : mem_rdata;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Two instances are used,
//               one with WAIT_STATES=0 and one with WAIT_STATES=3, each with
//               its own request inputs and its own behavioural memory.
//               Directed scenarios are followed by randomized traffic checked
//               against a transaction-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst;
    logic             mem_init;
    logic [1:0]       valid  [2];
    logic [1:0]       we     [2];
    logic [1:0][31:0] addr   [2];
    logic [1:0][31:0] wdata  [2];
    logic [1:0]       ready  [2];
    logic [1:0]       resp_v [2];
    logic [31:0]      resp_d [2];
    logic [1:0]       men, mwe, busy;
    logic [4:0]       maddr  [2];
    logic [31:0]      mwd    [2];
    logic [31:0]      mrd    [2];
    logic [31:0]      fmem   [2][32];

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_we(we[0]), .req_addr(addr[0]), .req_wdata(wdata[0]),
        .resp_valid(resp_v[0]), .resp_rdata(resp_d[0]), .mem_en(men[0]),
        .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mrd[0]), .busy(busy[0])
    );

    mem_arbiter #(.WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(rst[1]), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_we(we[1]), .req_addr(addr[1]), .req_wdata(wdata[1]),
        .resp_valid(resp_v[1]), .resp_rdata(resp_d[1]), .mem_en(men[1]),
        .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mrd[1]), .busy(busy[1])
    );

    function automatic logic [31:0] bg(input int k, input int a);
        return 32'h5A3C_0000 ^ (32'(a) * 32'h0101_0101) ^ 32'(k << 8);
    endfunction

    // Behavioural memories: combinational read, write on mem_we.
    always_comb begin
        mrd[0] = fmem[0][maddr[0]];
        mrd[1] = fmem[1][maddr[1]];
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 32; a++)
                    fmem[k][a] <= bg(k, a);
        end else begin
            for (int k = 0; k < 2; k++)
                if (mwe[k]) fmem[k][maddr[k]] <= mwd[k];
        end
    end

    task automatic do_reset(input int k);
        @(negedge clk); rst[k] = 1'b1; valid[k] = 2'b00;
        @(negedge clk); rst[k] = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); rst[0] = 1'b1; valid[0] = 2'b11; we[0] = 2'b00; #1;
        n_tests++; if (ready[0] !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", ready[0]); end
        n_tests++; if (resp_v[0] !== 2'b00) begin n_fail++; $display("FAIL rst_respv got %b exp 00", resp_v[0]); end
        n_tests++; if (men[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL rst_en_busy got %b%b exp 00", men[0], busy[0]); end
        @(negedge clk); #1;
        n_tests++; if (maddr[0] !== 5'd0 || resp_d[0] !== 32'd0) begin n_fail++; $display("FAIL rst_regs got addr %0d rdata %h exp 0 0", maddr[0], resp_d[0]); end
        n_tests++; if (ready[0] !== 2'b00 || mwe[0] !== 1'b0) begin n_fail++; $display("FAIL rst_hold got ready %b we %b exp 00 0", ready[0], mwe[0]); end
        @(negedge clk); rst[0] = 1'b0; #1;
        n_tests++; if (ready[0] !== 2'b01) begin n_fail++; $display("FAIL post_rst_ready got %b exp 01", ready[0]); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %b exp 0", busy[0]); end
        valid[0] = 2'b00;
    endtask

    task automatic test_store;
        @(negedge clk);
        valid[0] = 2'b10; we[0] = 2'b10; addr[0][1] = 32'h0000_0008; wdata[0][1] = 32'hDEAD_BEEF;
        addr[0][0] = 32'h0000_0044; wdata[0][0] = 32'h1111_1111; #1;
        n_tests++; if (ready[0] !== 2'b10) begin n_fail++; $display("FAIL st_ready got %b exp 10", ready[0]); end
        @(negedge clk);
        valid[0] = 2'b00; addr[0][1] = 32'h0000_0070; wdata[0][1] = 32'h0BAD_0BAD; we[0] = 2'b00; #1;
        n_tests++; if (men[0] !== 1'b1 || mwe[0] !== 1'b1) begin n_fail++; $display("FAIL st_strobe got en %b we %b exp 1 1", men[0], mwe[0]); end
        n_tests++; if (maddr[0] !== 5'd2 || mwd[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_mem got %0d %h exp 2 deadbeef", maddr[0], mwd[0]); end
        @(negedge clk); #1;
        n_tests++; if (resp_v[0] !== 2'b10 || resp_d[0] !== 32'd0) begin n_fail++; $display("FAIL st_resp got %b %h exp 10 0", resp_v[0], resp_d[0]); end
        n_tests++; if (men[0] !== 1'b0 || mwe[0] !== 1'b0) begin n_fail++; $display("FAIL st_resp_mem got %b%b exp 00", men[0], mwe[0]); end
        @(negedge clk); #1;
        n_tests++; if (busy[0] !== 1'b0 || resp_v[0] !== 2'b00) begin n_fail++; $display("FAIL st_idle got busy %b respv %b exp 0 00", busy[0], resp_v[0]); end
        n_tests++; if (maddr[0] !== 5'd2 || fmem[0][2] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st_written got addr %0d mem %h exp 2 deadbeef", maddr[0], fmem[0][2]); end
    endtask

    task automatic test_load;
        @(negedge clk); valid[0] = 2'b01; we[0] = 2'b00; addr[0][0] = 32'h0000_0008; #1;
        n_tests++; if (ready[0] !== 2'b01) begin n_fail++; $display("FAIL ld_ready got %b exp 01", ready[0]); end
        @(negedge clk); valid[0] = 2'b00; #1;
        n_tests++; if (men[0] !== 1'b1 || mwe[0] !== 1'b0 || maddr[0] !== 5'd2) begin n_fail++; $display("FAIL ld_access got %b %b %0d exp 1 0 2", men[0], mwe[0], maddr[0]); end
        @(negedge clk); #1;
        n_tests++; if (resp_v[0] !== 2'b01 || resp_d[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_resp got %b %h exp 01 deadbeef", resp_v[0], resp_d[0]); end
        @(negedge clk); #1;
        n_tests++; if (resp_d[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_hold got %h exp deadbeef", resp_d[0]); end
    endtask

    task automatic test_addr;
        logic [31:0] a_tab [2];
        int          e_tab [2];
        a_tab[0] = 32'h0000_0085; e_tab[0] = 1;
        a_tab[1] = 32'hFFFF_FFFC; e_tab[1] = 31;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); valid[0] = 2'b10; we[0] = 2'b00; addr[0][1] = a_tab[i]; #1;
            n_tests++; if (ready[0] !== 2'b10) begin n_fail++; $display("FAIL addr%0d_ready got %b exp 10", i, ready[0]); end
            @(negedge clk); valid[0] = 2'b00; #1;
            n_tests++; if (maddr[0] !== 5'(e_tab[i])) begin n_fail++; $display("FAIL addr%0d_index got %0d exp %0d", i, maddr[0], e_tab[i]); end
            @(negedge clk); #1;
            n_tests++; if (resp_v[0] !== 2'b10 || resp_d[0] !== bg(0, e_tab[i])) begin n_fail++; $display("FAIL addr%0d_resp got %b %h exp 10 %h", i, resp_v[0], resp_d[0], bg(0, e_tab[i])); end
        end
        @(negedge clk);
    endtask

    task automatic test_alternate;
        int acc_cyc [$];
        int acc_port [$];
        do_reset(0);
        valid[0] = 2'b11; we[0] = 2'b00; addr[0][0] = 32'h10; addr[0][1] = 32'h20;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ready[0] == 2'b01) begin acc_cyc.push_back(c); acc_port.push_back(0); end
            if (ready[0] == 2'b10) begin acc_cyc.push_back(c); acc_port.push_back(1); end
        end
        @(negedge clk); valid[0] = 2'b00;
        repeat (3) @(negedge clk);
        n_tests++; if (acc_cyc.size() != 4) begin n_fail++; $display("FAIL alt_count got %0d exp 4", acc_cyc.size()); end
        for (int i = 0; i < 4 && i < acc_cyc.size(); i++) begin
            n_tests++; if (acc_cyc[i] != 3 * i || acc_port[i] != i % 2) begin n_fail++; $display("FAIL alt_grant%0d got cyc %0d port %0d exp %0d %0d", i, acc_cyc[i], acc_port[i], 3 * i, i % 2); end
        end
    endtask

    task automatic test_wait3;
        do_reset(1);
        valid[1] = 2'b01; we[1] = 2'b00; addr[1][0] = 32'h0000_0040; #1;
        n_tests++; if (ready[1] !== 2'b01) begin n_fail++; $display("FAIL w3_ready got %b exp 01", ready[1]); end
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk); valid[1] = 2'b00; #1;
            n_tests++; if (men[1] !== (j <= 4) || mwe[1] !== 1'b0) begin n_fail++; $display("FAIL w3_mem T+%0d got en %b we %b exp %b 0", j, men[1], mwe[1], (j <= 4)); end
            n_tests++; if (resp_v[1] !== ((j == 5) ? 2'b01 : 2'b00) || busy[1] !== (j <= 5)) begin n_fail++; $display("FAIL w3_resp T+%0d got respv %b busy %b", j, resp_v[1], busy[1]); end
            if (j == 5) begin
                n_tests++; if (resp_d[1] !== bg(1, 16)) begin n_fail++; $display("FAIL w3_rdata got %h exp %h", resp_d[1], bg(1, 16)); end
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        valid[1] = 2'b01; we[1] = 2'b01; addr[1][0] = 32'h0000_0030; wdata[1][0] = 32'h1234_5678; #1;
        n_tests++; if (ready[1] !== 2'b01) begin n_fail++; $display("FAIL rm_ready got %b exp 01", ready[1]); end
        @(negedge clk); valid[1] = 2'b00; #1;
        n_tests++; if (men[1] !== 1'b1 || mwe[1] !== 1'b0) begin n_fail++; $display("FAIL rm_t1 got en %b we %b exp 1 0", men[1], mwe[1]); end
        @(negedge clk); rst[1] = 1'b1; #1;
        n_tests++; if (mwe[1] !== 1'b0 || men[1] !== 1'b0 || resp_v[1] !== 2'b00) begin n_fail++; $display("FAIL rm_t2 got we %b en %b respv %b exp 0 0 00", mwe[1], men[1], resp_v[1]); end
        @(negedge clk); rst[1] = 1'b0; valid[1] = 2'b11; we[1] = 2'b00; #1;
        n_tests++; if (ready[1] !== 2'b01) begin n_fail++; $display("FAIL rm_rrptr got %b exp 01", ready[1]); end
        valid[1] = 2'b00;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); #1;
            n_tests++; if (resp_v[1] !== 2'b00 || mwe[1] !== 1'b0 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL rm_quiet%0d got respv %b we %b busy %b", j, resp_v[1], mwe[1], busy[1]); end
        end
        n_tests++; if (fmem[1][12] !== bg(1, 12)) begin n_fail++; $display("FAIL rm_mem got %h exp %h", fmem[1][12], bg(1, 12)); end
    endtask

    // Reference model: each accepted request owns a fixed timeline measured
    // from its handshake cycle t: memory cycles t+1..t+ws+1, response at
    // t+ws+2, free again at t+ws+3.
    task automatic test_random(input int k, input int ws, input int n);
        logic        m_active, m_port, m_we, m_rr, rs, win;
        int          m_tacc, d;
        logic [4:0]  m_idx;
        logic [31:0] m_wd, m_resp;
        logic [31:0] m_mem [32];
        logic [1:0]  e_ready, e_rv;
        logic        e_en, e_we, e_busy;
        m_active = 1'b0; m_port = 1'b0; m_we = 1'b0; m_rr = 1'b0; m_tacc = 0;
        m_idx = 5'd0; m_wd = 32'd0; m_resp = 32'd0;
        for (int a = 0; a < 32; a++) m_mem[a] = bg(k, a);
        @(negedge clk); rst[k] = 1'b1; valid[k] = 2'b00; mem_init = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_init = 1'b0;
            rs = ($urandom_range(0, 39) == 0);
            rst[k] = rs;
            valid[k] = 2'($urandom_range(0, 3));
            we[k] = 2'($urandom_range(0, 3));
            addr[k][0] = $urandom; addr[k][1] = $urandom;
            wdata[k][0] = $urandom; wdata[k][1] = $urandom;
            #1;
            d = i - m_tacc;
            win = (valid[k] == 2'b11) ? m_rr : valid[k][1];
            e_ready = (!m_active && !rs && valid[k] != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
            e_en    = m_active && !rs && (d <= ws + 1);
            e_we    = e_en && (d == ws + 1) && m_we;
            e_rv    = (m_active && !rs && d == ws + 2) ? (m_port ? 2'b10 : 2'b01) : 2'b00;
            e_busy  = m_active && !rs;
            n_tests++; if (ready[k] !== e_ready) begin n_fail++; $display("FAIL rnd%0d c%0d ready got %b exp %b", k, i, ready[k], e_ready); end
            n_tests++; if (men[k] !== e_en || mwe[k] !== e_we) begin n_fail++; $display("FAIL rnd%0d c%0d mem_en/we got %b%b exp %b%b", k, i, men[k], mwe[k], e_en, e_we); end
            n_tests++; if (maddr[k] !== m_idx || mwd[k] !== m_wd) begin n_fail++; $display("FAIL rnd%0d c%0d mem_addr/wdata got %0d %h exp %0d %h", k, i, maddr[k], mwd[k], m_idx, m_wd); end
            n_tests++; if (resp_v[k] !== e_rv || resp_d[k] !== m_resp) begin n_fail++; $display("FAIL rnd%0d c%0d resp got %b %h exp %b %h", k, i, resp_v[k], resp_d[k], e_rv, m_resp); end
            n_tests++; if (busy[k] !== e_busy) begin n_fail++; $display("FAIL rnd%0d c%0d busy got %b exp %b", k, i, busy[k], e_busy); end
            if (rs) begin
                m_active = 1'b0; m_rr = 1'b0; m_idx = 5'd0; m_wd = 32'd0; m_resp = 32'd0;
            end else if (m_active) begin
                if (d == ws + 1) begin
                    m_resp = m_we ? 32'd0 : m_mem[m_idx];
                    if (m_we) m_mem[m_idx] = m_wd;
                end
                if (d == ws + 2) m_active = 1'b0;
            end else if (e_ready != 2'b00) begin
                m_active = 1'b1; m_tacc = i; m_port = win; m_we = we[k][win];
                m_idx = addr[k][win][6:2]; m_wd = wdata[k][win]; m_rr = ~win;
            end
        end
        @(negedge clk); rst[k] = 1'b1; valid[k] = 2'b00;
        @(negedge clk); rst[k] = 1'b0;
    endtask

    initial begin
        rst = 2'b11; mem_init = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 2'b00; we[k] = 2'b00; addr[k] = '0; wdata[k] = '0;
        end
        @(negedge clk); @(negedge clk);
        rst = 2'b00; mem_init = 1'b0;
        test_reset;
        test_store;
        test_load;
        test_addr;
        test_alternate;
        test_wait3;
        test_reset_mid;
        test_random(0, 0, 400);
        test_random(1, 3, 400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
